// File: rtl/bus_irq_controller_if.sv
`default_nettype none
// ============================================================================
// bus_irq_controller_if : processor bus address/strobe and IRQ handshake
// Rev 1.0
// ============================================================================
interface bus_irq_controller_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_SRC    = 8,
   parameter int ID_WIDTH   = 3
);
   logic [ADDR_WIDTH-1:0] BUS_ADDR;
   logic                  BUS_WE;
   logic [NUM_SRC-1:0]    SRC_IRQ;
   logic                  IRQ_ACK;
   logic                  IRQ_RAISE;
   logic [ID_WIDTH-1:0]   IRQ_ID;

   modport master (
      output BUS_ADDR, BUS_WE, SRC_IRQ, IRQ_ACK,
      input  IRQ_RAISE, IRQ_ID
   );

   modport slave (
      input  BUS_ADDR, BUS_WE, SRC_IRQ, IRQ_ACK,
      output IRQ_RAISE, IRQ_ID
   );
endinterface
`default_nettype wire

// File: rtl/bus_irq_controller.sv
`default_nettype none
// ============================================================================
// bus_irq_controller : edge-detect, mask, fixed-priority IRQ raise/ack/EOI
// Optional ack timeout: define IRQ_CTRL_ACK_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module bus_irq_controller #(
   parameter int                    NUM_SRC     = 8,
   parameter int                    ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 8'hD0,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ACK_TIMEOUT = 255
) (
   input  wire                  CLK,
   input  wire                  RESET,
   inout  wire [DATA_WIDTH-1:0] BUS_DATA,
   bus_irq_controller_if.slave  bus
);
   localparam int c_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   if (NUM_SRC < 1 || NUM_SRC > DATA_WIDTH || c_ID_W > DATA_WIDTH - 2) begin : g_chk_width
      $error("bus_irq_controller: NUM_SRC out of range for DATA_WIDTH");
   end
   if (ACK_TIMEOUT < 1) begin : g_chk_timeout
      $error("bus_irq_controller: ACK_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RAISE   = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t                r_state;
   logic [NUM_SRC-1:0]    r_src_q;
   logic [NUM_SRC-1:0]    r_pending;
   logic [NUM_SRC-1:0]    r_mask;
   logic                  r_irq_raise;
   logic [c_ID_W-1:0]     r_irq_id;
   logic                  r_oe;
   logic [DATA_WIDTH-1:0] r_rdata;
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
   localparam int                c_TO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);
   logic [c_TO_W-1:0]     r_to_cnt;
   logic                  r_timeout;
`endif

   logic [ADDR_WIDTH-1:0] w_offset;
   logic                  w_hit;
   logic                  w_wr;
   logic                  w_rd;
   logic [1:0]            w_reg;
   logic                  w_eoi;
   logic [NUM_SRC-1:0]    w_set;
   logic [NUM_SRC-1:0]    w_clr;
   logic [NUM_SRC-1:0]    w_ack_clr;
   logic [NUM_SRC-1:0]    w_req;
   logic [c_ID_W-1:0]     w_lowest;
   logic [DATA_WIDTH-1:0] w_pend_ext;
   logic [DATA_WIDTH-1:0] w_mask_ext;
   logic [DATA_WIDTH-1:0] w_active;
   logic [DATA_WIDTH-1:0] w_rd_mux;

   always_comb begin
      w_offset = bus.BUS_ADDR - BASE_ADDR;
      w_hit    = (w_offset[ADDR_WIDTH-1:2] == '0);
      w_reg    = w_offset[1:0];
      w_wr     = w_hit & bus.BUS_WE;
      w_rd     = w_hit & ~bus.BUS_WE;
      w_eoi    = w_wr && (w_reg == 2'd3) && (r_state == S_SERVICE);

      w_set     = bus.SRC_IRQ & ~r_src_q;
      w_clr     = (w_wr && (w_reg == 2'd0)) ? BUS_DATA[NUM_SRC-1:0] : '0;
      w_ack_clr = '0;
      if (r_state == S_RAISE && bus.IRQ_ACK) begin
         w_ack_clr[r_irq_id] = 1'b1;
      end

      // Scan downwards so the lowest requesting index is the one left standing.
      w_req    = r_pending & r_mask;
      w_lowest = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_lowest = c_ID_W'(i);
         end
      end

      w_pend_ext                 = '0;
      w_pend_ext[NUM_SRC-1:0]    = r_pending;
      w_mask_ext                 = '0;
      w_mask_ext[NUM_SRC-1:0]    = r_mask;
      w_active                   = '0;
      w_active[c_ID_W-1:0]       = r_irq_id;
      w_active[DATA_WIDTH-1]     = (r_state == S_SERVICE);
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
      w_active[DATA_WIDTH-2]     = r_timeout;
`endif

      case (w_reg)
         2'd0:    w_rd_mux = w_pend_ext;
         2'd1:    w_rd_mux = w_mask_ext;
         2'd2:    w_rd_mux = w_active;
         default: w_rd_mux = '0;
      endcase
   end

   // Set is OR-ed in after the clears so a coincident edge always wins.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_src_q   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_oe      <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_src_q   <= bus.SRC_IRQ;
         r_pending <= (r_pending & ~(w_clr | w_ack_clr)) | w_set;
         if (w_wr && (w_reg == 2'd1)) begin
            r_mask <= BUS_DATA[NUM_SRC-1:0];
         end
         r_oe    <= w_rd;
         r_rdata <= w_rd_mux;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= S_IDLE;
         r_irq_raise <= 1'b0;
         r_irq_id    <= '0;
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
         r_to_cnt    <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_req) begin
                  r_irq_id    <= w_lowest;
                  r_irq_raise <= 1'b1;
                  r_state     <= S_RAISE;
               end
            end
            S_RAISE: begin
               if (bus.IRQ_ACK) begin
                  r_irq_raise <= 1'b0;
                  r_state     <= S_SERVICE;
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
                  r_to_cnt    <= '0;
               end else if (r_to_cnt == c_TO_LAST) begin
                  r_irq_raise <= 1'b0;
                  r_timeout   <= 1'b1;
                  r_to_cnt    <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  r_to_cnt    <= r_to_cnt + 1'b1;
`endif
               end
            end
            S_SERVICE: begin
               if (w_eoi) begin
                  r_state   <= S_IDLE;
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
                  r_timeout <= 1'b0;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign BUS_DATA      = r_oe ? r_rdata : {DATA_WIDTH{1'bz}};
   assign bus.IRQ_RAISE = r_irq_raise;
   assign bus.IRQ_ID    = r_irq_id;
endmodule
`default_nettype wire

// File: tb/tb_bus_irq_controller.sv
`default_nettype none
// tb_bus_irq_controller : scoreboard bench; expected reads and raised IDs are
// queued when stimulus is applied and compared when the DUT responds.
module tb_bus_irq_controller;
   localparam int         ID_W   = 3;
   localparam logic [7:0] A_PEND = 8'hD0;
   localparam logic [7:0] A_MASK = 8'hD1;
   localparam logic [7:0] A_ACT  = 8'hD2;
   localparam logic [7:0] A_EOI  = 8'hD3;
   localparam logic [7:0] A_NONE = 8'h00;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       tb_drv   = 1'b0;
   logic [7:0] tb_wdata = 8'h00;
   wire  [7:0] bus_data;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0]      rd_exp_q[$];
   logic [ID_W-1:0] irq_exp_q[$];

   bus_irq_controller_if #(.ADDR_WIDTH(8), .NUM_SRC(8), .ID_WIDTH(ID_W)) bif ();

   assign bus_data = tb_drv ? tb_wdata : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup pu (bus_data[i]);
   end

   bus_irq_controller #(
      .NUM_SRC(8), .ADDR_WIDTH(8), .BASE_ADDR(8'hD0), .DATA_WIDTH(8), .ACK_TIMEOUT(4)
   ) dut (
      .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .bus(bif.slave)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      bif.BUS_ADDR = a; bif.BUS_WE = 1'b1; tb_wdata = d; tb_drv = 1'b1;
      @(negedge clk);
      bif.BUS_WE = 1'b0; tb_drv = 1'b0; bif.BUS_ADDR = A_NONE;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      bif.BUS_ADDR = a; bif.BUS_WE = 1'b0;
      @(negedge clk);
      d = bus_data;
      bif.BUS_ADDR = A_NONE;
      @(negedge clk);
   endtask

   task automatic pulse_src(input logic [7:0] s);
      bif.SRC_IRQ = s;
      @(negedge clk);
      bif.SRC_IRQ = 8'h00;
   endtask

   task automatic pulse_ack;
      bif.IRQ_ACK = 1'b1;
      @(negedge clk);
      bif.IRQ_ACK = 1'b0;
   endtask

   task automatic wait_raise(output int cyc);
      cyc = 0;
      while (bif.IRQ_RAISE !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      logic [7:0] got, exp;
      #2;
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL reset_raise: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      n_checks++; if (bif.IRQ_ID !== 3'd0) $display("FAIL reset_id: got %0d, expected 0", bif.IRQ_ID); else n_pass++;
      n_checks++; if (bus_data !== 8'hFF) $display("FAIL reset_bus_z: got %h, expected released (ff)", bus_data); else n_pass++;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      rd_exp_q.push_back(8'h00); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL reset_pending: got %h, expected %h", got, exp); else n_pass++;
      rd_exp_q.push_back(8'h00); bus_read(A_MASK, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL reset_mask: got %h, expected %h", got, exp); else n_pass++;
   endtask

   task automatic test_priority;
      logic [7:0] got, exp; logic [ID_W-1:0] eid; int cyc;
      bus_write(A_MASK, 8'hFF);
      irq_exp_q.push_back(3'd2); irq_exp_q.push_back(3'd5);
      pulse_src(8'h24);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || cyc != 1) $display("FAIL prio_latency: got raise=%b after %0d, expected 1 after 1", bif.IRQ_RAISE, cyc); else n_pass++;
      n_checks++; if (bif.IRQ_ID !== eid) $display("FAIL prio_first_id: got %0d, expected %0d", bif.IRQ_ID, eid); else n_pass++;
      pulse_ack;
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL prio_ack_drop: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h20); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL prio_pending: got %h, expected %h", got, exp); else n_pass++;
      bus_write(A_EOI, 8'h00);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || cyc != 1) $display("FAIL prio_eoi_latency: got raise=%b after %0d, expected 1 after 1", bif.IRQ_RAISE, cyc); else n_pass++;
      n_checks++; if (bif.IRQ_ID !== eid) $display("FAIL prio_second_id: got %0d, expected %0d", bif.IRQ_ID, eid); else n_pass++;
      pulse_ack;
      bus_write(A_EOI, 8'h00);
   endtask

   task automatic test_masking;
      logic [7:0] got, exp; logic [ID_W-1:0] eid; int cyc;
      bus_write(A_MASK, 8'h00);
      pulse_src(8'h08);
      repeat (3) @(negedge clk);
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL mask_no_raise: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h08); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL mask_pending: got %h, expected %h", got, exp); else n_pass++;
      irq_exp_q.push_back(3'd3);
      bus_write(A_MASK, 8'h08);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || bif.IRQ_ID !== eid) $display("FAIL mask_enable_raise: got raise=%b id=%0d, expected 1 id=%0d", bif.IRQ_RAISE, bif.IRQ_ID, eid); else n_pass++;
      bus_write(A_PEND, 8'h08);
      n_checks++; if (bif.IRQ_RAISE !== 1'b1) $display("FAIL mask_w1c_hold: got %b, expected 1", bif.IRQ_RAISE); else n_pass++;
      pulse_ack;
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL mask_ack: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h00); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL mask_pend_cleared: got %h, expected %h", got, exp); else n_pass++;
      bus_write(A_EOI, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL mask_no_reraise: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
   endtask

   task automatic test_handshake;
      logic [7:0] got, exp; logic [ID_W-1:0] eid; int cyc;
      bus_write(A_MASK, 8'hFF);
      irq_exp_q.push_back(3'd1);
      pulse_src(8'h02);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || bif.IRQ_ID !== eid) $display("FAIL hs_raise: got raise=%b id=%0d, expected 1 id=%0d", bif.IRQ_RAISE, bif.IRQ_ID, eid); else n_pass++;
      pulse_ack;
      pulse_src(8'h01);
      repeat (3) @(negedge clk);
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL hs_service_block: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h81); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL hs_active: got %h, expected %h", got, exp); else n_pass++;
      irq_exp_q.push_back(3'd0);
      bus_write(A_EOI, 8'h00);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || cyc != 1 || bif.IRQ_ID !== eid) $display("FAIL hs_eoi_reraise: got raise=%b after %0d id=%0d, expected 1 after 1 id=%0d", bif.IRQ_RAISE, cyc, bif.IRQ_ID, eid); else n_pass++;
      pulse_ack;
      bus_write(A_EOI, 8'h00);
      pulse_ack;
      repeat (2) @(negedge clk);
      n_checks++; if (bif.IRQ_RAISE !== 1'b0) $display("FAIL hs_stray_ack: got %b, expected 0", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h00); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL hs_idle_active: got %h, expected %h", got, exp); else n_pass++;
   endtask

   task automatic test_collision;
      logic [7:0] got, exp;
      bus_write(A_MASK, 8'h00);
      bif.BUS_ADDR = A_PEND; bif.BUS_WE = 1'b1; tb_wdata = 8'h01; tb_drv = 1'b1;
      bif.SRC_IRQ = 8'h01;
      @(negedge clk);
      bif.BUS_WE = 1'b0; tb_drv = 1'b0; bif.BUS_ADDR = A_NONE; bif.SRC_IRQ = 8'h00;
      rd_exp_q.push_back(8'h01); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL collide_set_wins: got %h, expected %h", got, exp); else n_pass++;
      bus_write(A_PEND, 8'h01);
      rd_exp_q.push_back(8'h00); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL collide_w1c: got %h, expected %h", got, exp); else n_pass++;
   endtask

   task automatic test_async_reset;
      logic [7:0] got, exp; logic [ID_W-1:0] eid; int cyc;
      bus_write(A_MASK, 8'hFF);
      irq_exp_q.push_back(3'd4);
      pulse_src(8'h10);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || bif.IRQ_ID !== eid) $display("FAIL areset_pre_raise: got raise=%b id=%0d, expected 1 id=%0d", bif.IRQ_RAISE, bif.IRQ_ID, eid); else n_pass++;
      #3 rst = 1'b1;
      #1;
      n_checks++; if (bif.IRQ_RAISE !== 1'b0 || bif.IRQ_ID !== 3'd0) $display("FAIL areset_outputs: got raise=%b id=%0d, expected 0 id=0", bif.IRQ_RAISE, bif.IRQ_ID); else n_pass++;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      rd_exp_q.push_back(8'h00); bus_read(A_PEND, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL areset_pending: got %h, expected %h", got, exp); else n_pass++;
      rd_exp_q.push_back(8'h00); bus_read(A_MASK, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL areset_mask: got %h, expected %h", got, exp); else n_pass++;
      n_checks++; if (bus_data !== 8'hFF) $display("FAIL areset_bus_z: got %h, expected released (ff)", bus_data); else n_pass++;
   endtask

   task automatic test_ack_timeout;
      logic [7:0] got, exp; logic [ID_W-1:0] eid; int cyc;
      bus_write(A_MASK, 8'h04);
      irq_exp_q.push_back(3'd2);
      pulse_src(8'h04);
      wait_raise(cyc); eid = irq_exp_q.pop_front();
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || bif.IRQ_ID !== eid) $display("FAIL to_raise: got raise=%b id=%0d, expected 1 id=%0d", bif.IRQ_RAISE, bif.IRQ_ID, eid); else n_pass++;
`ifdef IRQ_CTRL_ACK_TIMEOUT_EN
      cyc = 0;
      while (bif.IRQ_RAISE === 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (cyc != 4) $display("FAIL to_drop_cycles: got %0d, expected 4", cyc); else n_pass++;
      rd_exp_q.push_back(8'h42); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL to_flag: got %h, expected %h", got, exp); else n_pass++;
      n_checks++; if (bif.IRQ_RAISE !== 1'b1 || bif.IRQ_ID !== 3'd2) $display("FAIL to_reraise: got raise=%b id=%0d, expected 1 id=2", bif.IRQ_RAISE, bif.IRQ_ID); else n_pass++;
      pulse_ack;
      rd_exp_q.push_back(8'hC2); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL to_service_flag: got %h, expected %h", got, exp); else n_pass++;
      bus_write(A_EOI, 8'h00);
      rd_exp_q.push_back(8'h02); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL to_flag_clear: got %h, expected %h", got, exp); else n_pass++;
`else
      repeat (10) @(negedge clk);
      n_checks++; if (bif.IRQ_RAISE !== 1'b1) $display("FAIL hold_no_timeout: got %b, expected 1", bif.IRQ_RAISE); else n_pass++;
      rd_exp_q.push_back(8'h02); bus_read(A_ACT, got); exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL hold_active: got %h, expected %h", got, exp); else n_pass++;
      pulse_ack;
      bus_write(A_EOI, 8'h00);
`endif
   endtask

   initial begin
      bif.BUS_ADDR = A_NONE;
      bif.BUS_WE   = 1'b0;
      bif.SRC_IRQ  = 8'h00;
      bif.IRQ_ACK  = 1'b0;
      test_reset();
      test_priority();
      test_masking();
      test_handshake();
      test_collision();
      test_async_reset();
      test_ack_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, expected finish earlier");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/bus_irq_controller.md
Name: bus_irq_controller

Overview:
- Parameterised interrupt controller between N peripheral interrupt sources (mouse, timer, IR, etc.) and the single-line interrupt raise/ack handshake of the 8-bit processor.
- Memory-mapped on the shared processor bus (BUS_ADDR / BUS_DATA / BUS_WE).
- Edge-detects sources, latches pending bits, applies a software mask, selects by fixed priority, and tracks one in-service interrupt until software writes end-of-interrupt (EOI).

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..DATA_WIDTH.
- BASE_ADDR, 8'hD0, bus address of register 0; the block occupies BASE_ADDR..BASE_ADDR+3.
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 8, bus data width.
- ACK_TIMEOUT, 255, cycles to wait for CPU ack (used only with the optional feature).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BUS_ADDR  in  ADDR_WIDTH  processor bus address.
- BUS_DATA  inout  DATA_WIDTH  shared tristate data bus; driven only during this block's read cycle, else Z.
- BUS_WE  in  1  bus write enable; write occurs on the cycle it is high with a matching address.
- SRC_IRQ  in  NUM_SRC  peripheral interrupt requests, synchronous to CLK.
- IRQ_RAISE  out  1  interrupt request to processor.
- IRQ_ACK  in  1  processor acknowledge, single-cycle pulse.
- IRQ_ID  out  clog2(NUM_SRC) (min 1)  index of the raised or in-service source.

Behaviour:
- Reset (asynchronous, active-high) clears: PENDING, MASK, edge-detect history, FSM to IDLE, IRQ_RAISE=0, IRQ_ID=0, bus driver released (BUS_DATA=Z). Reset mid-handshake aborts it silently.
- Edge detect: src_q <= SRC_IRQ each cycle. A rising edge (SRC_IRQ & ~src_q) sets PENDING[i]. Level-high sources set pending once only.
- Register map, offset from BASE_ADDR:
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 ACTIVE: read; bit7 = in-service flag, low bits = IRQ_ID.
  - 3 EOI: write any value ends service; reads as 0.
- Unused upper bits of PENDING and MASK read 0.
- Bus read: address match with BUS_WE=0 → data is registered and driven on BUS_DATA the following cycle, for exactly one cycle. No match → Z.
- Simultaneous set and clear of the same pending bit: the set wins.
- FSM states:
  - IDLE: if (PENDING & MASK) != 0, latch the lowest set index into IRQ_ID and go to RAISE. IRQ_RAISE goes high on the same edge, so latency from source edge to IRQ_RAISE is 2 cycles.
  - RAISE: hold IRQ_RAISE=1 and IRQ_ID stable. When IRQ_ACK=1 is sampled: clear PENDING[IRQ_ID], IRQ_RAISE<=0, go to SERVICE. Clearing the mask bit while in RAISE does not withdraw the request.
  - SERVICE: no new raise is issued. A write to EOI returns the FSM to IDLE. A new request can raise 1 cycle after the EOI write.
- IRQ_ACK received in IDLE or SERVICE is ignored.
- An EOI write outside SERVICE is ignored.

Optional Feature:
- Macro: IRQ_CTRL_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while in RAISE.
  - If ACK_TIMEOUT cycles elapse without IRQ_ACK: drop IRQ_RAISE, leave PENDING set, set sticky flag ACTIVE bit6 (timeout), return to IDLE. The same source is re-raised on the next IDLE evaluation.
  - Bit6 clears on EOI write or reset.
  - An ack arriving on the timeout cycle takes precedence over the timeout.
- Undefined: no counter; RAISE waits indefinitely; bit6 reads 0.

Test Plan:
- Reset: assert RESET mid-RAISE at an arbitrary time, not clock-aligned → IRQ_RAISE=0 immediately; reads at D0/D1 return 8'h00; BUS_DATA=Z when the block is not addressed.
- Priority: MASK=8'hFF, pulse SRC_IRQ bits 5 and 2 in the same cycle → IRQ_RAISE high 2 cycles later with IRQ_ID=2; ack → read D0=8'h20; EOI → IRQ_ID=5 raised 1 cycle later.
- Masking: MASK=8'h00, pulse SRC_IRQ[3] → PENDING=8'h08, no raise; write MASK=8'h08 → raise with ID=3; write D0=8'h08 while RAISE is held → raise stays until ack.
- Handshake: during SERVICE pulse SRC_IRQ[0] → no raise until EOI; read D2=8'h80|ID during SERVICE; stray IRQ_ACK in IDLE → no state change.
- Set/clear collision: write D0=8'h01 on the same cycle as a rising edge of SRC_IRQ[0] → PENDING[0] stays 1.
- Timeout (macro defined, ACK_TIMEOUT=4): raise, withhold ack → IRQ_RAISE drops after 4 cycles, D2 bit6=1, re-raise follows; ack then EOI → bit6 clears.
